program_memory: RTL and testbench

PROGRAM_MEMORY -- requirements
Module: program_memory

---
 rtl/program_memory.sv | 85 ++++++++
 tb/tb_program_memory.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// Byte-wide program store: a loader streams an image in, then the CPU reads it combinationally.
// memVal has zero-cycle latency; ldReady drops for the whole RUN phase until ldStart restarts a load.
module program_memory #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memVal,
   input  logic              ldValid,
   input  logic [DATA_W-1:0] ldData,
   input  logic              ldLast,
   output logic              ldReady,
   input  logic              ldStart,
   output logic              cpuRun,
   output logic [ADDR_W:0]   ldCount
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   ld_count_q, ld_count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              accept;
   logic              wr_full;

   assign ldReady = (state_q != RUN);
   assign accept  = ldValid && ldReady;
   assign wr_full = (wr_ptr_q == {ADDR_W{1'b1}});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         ld_count_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         ld_count_q <= ld_count_d;
      end
   end

   // The top address always closes the load so the pointer can never wrap onto byte 0.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      ld_count_d = ld_count_q;
      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               wr_ptr_d   = wr_ptr_q + 1'b1;
               ld_count_d = ld_count_q + 1'b1;
               state_d    = (ldLast || wr_full) ? RUN : LOAD;
            end
         end
         RUN: begin
            if (ldStart) begin
               state_d    = IDLE;
               wr_ptr_d   = '0;
               ld_count_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (accept) begin
         mem_q[wr_ptr_q] <= ldData;
      end
   end

   assign cpuRun  = (state_q == RUN);
   assign memVal  = cpuRun ? mem_q[memAddr] : '0;
   assign ldCount = ld_count_q;

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: expectations are queued at stimulus time and popped at each check.
module tb_program_memory;

   logic       clk;
   logic       rst;
   logic [7:0] memAddr;
   logic [7:0] memVal;
   logic       ldValid;
   logic [7:0] ldData;
   logic       ldLast;
   logic       ldReady;
   logic       ldStart;
   logic       cpuRun;
   logic [8:0] ldCount;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q [$];
   string       tag_q [$];

   program_memory #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .memAddr (memAddr),
      .memVal  (memVal),
      .ldValid (ldValid),
      .ldData  (ldData),
      .ldLast  (ldLast),
      .ldReady (ldReady),
      .ldStart (ldStart),
      .cpuRun  (cpuRun),
      .ldCount (ldCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [15:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input logic [15:0] obs);
      logic [15:0] e;
      string       t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      ldValid = 1'b1;
      ldData  = d;
      ldLast  = last;
      tick();
      ldValid = 1'b0;
      ldLast  = 1'b0;
   endtask

   task automatic read(input string tag, input logic [7:0] addr, input logic [7:0] v);
      memAddr = addr;
      push(tag, {8'h00, v});
      #1;
      chk({8'h00, memVal});
   endtask

   task automatic status(input string tag, input logic run, input logic [8:0] cnt);
      push({tag, "_run"}, {15'h0, run});
      chk({15'h0, cpuRun});
      push({tag, "_cnt"}, {7'h0, cnt});
      chk({7'h0, ldCount});
   endtask

   initial begin
      rst = 1'b0; memAddr = '0; ldValid = 1'b0; ldData = '0; ldLast = 1'b0; ldStart = 1'b0;
      #2;
      status("reset", 1'b0, 9'd0);
      push("reset_rdy", 16'd1);
      chk({15'h0, ldReady});
      read("reset_val", 8'h00, 8'h00);
      tick(); tick();
      rst = 1'b1;

      // Three-byte image closed by ldLast
      send(8'h11, 1'b0);
      status("ld1", 1'b0, 9'd1);
      send(8'h22, 1'b0);
      status("ld2", 1'b0, 9'd2);
      send(8'h33, 1'b1);
      status("ld3", 1'b1, 9'd3);
      push("run_rdy", 16'd0);
      chk({15'h0, ldReady});
      read("ld3_a1", 8'h01, 8'h22);
      read("ld3_a3", 8'h03, 8'h00);
      read("ld3_a0", 8'h00, 8'h11);

      // Loader bytes are ignored while running
      send(8'h99, 1'b1);
      status("run_ign", 1'b1, 9'd3);
      read("run_ign_a3", 8'h03, 8'h00);

      // Reload: ldStart, then a single byte overwrites addr 0 only
      ldStart = 1'b1;
      tick();
      ldStart = 1'b0;
      status("restart", 1'b0, 9'd0);
      push("restart_rdy", 16'd1);
      chk({15'h0, ldReady});
      read("restart_val", 8'h00, 8'h00);
      send(8'h77, 1'b1);
      status("reload", 1'b1, 9'd1);
      read("reload_a0", 8'h00, 8'h77);
      read("reload_a1", 8'h01, 8'h22);

      // Asynchronous reset in the middle of a load
      ldStart = 1'b1;
      tick();
      ldStart = 1'b0;
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      status("pre_rst", 1'b0, 9'd2);
      #2;
      rst = 1'b0;
      #1;
      status("async_rst", 1'b0, 9'd0);
      read("async_rst_val", 8'h00, 8'h00);
      ldValid = 1'b1;
      ldData  = 8'hEE;
      ldLast  = 1'b1;
      tick();
      status("rst_held", 1'b0, 9'd0);
      push("rst_held_rdy", 16'd1);
      chk({15'h0, ldReady});
      rst = 1'b1;
      send(8'hC3, 1'b1);
      status("post_rst", 1'b1, 9'd1);
      read("post_rst_a0", 8'h00, 8'hC3);
      read("post_rst_a1", 8'h01, 8'h00);
      read("post_rst_a2", 8'h02, 8'h00);

      // Single byte with ldLast straight from IDLE
      ldStart = 1'b1;
      tick();
      ldStart = 1'b0;
      send(8'hA5, 1'b1);
      status("single", 1'b1, 9'd1);
      read("single_a0", 8'h00, 8'hA5);

      // Full-depth image without ldLast, with a stall and a stray ldLast mid-way
      ldStart = 1'b1;
      tick();
      ldStart = 1'b0;
      for (int i = 0; i < 256; i++) begin
         send(8'(i), 1'b0);
         if (i == 9) begin
            repeat (5) tick();
            ldLast = 1'b1;
            tick();
            ldLast = 1'b0;
            status("stall", 1'b0, 9'd10);
            push("stall_rdy", 16'd1);
            chk({15'h0, ldReady});
         end
         if (i == 254) status("full_m1", 1'b0, 9'd255);
      end
      status("full", 1'b1, 9'd256);
      read("full_aff", 8'hFF, 8'hFF);
      read("full_a80", 8'h80, 8'h80);
      read("full_a00", 8'h00, 8'h00);
      repeat (3) tick();
      status("full_hold", 1'b1, 9'd256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
